// File: rtl/ram_master_pkg.sv
// Shared state encoding and default geometry for the RAM bus master.
package ram_master_pkg;

  localparam int ADDR_W_DEF    = 28;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 56;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_bus_master.sv
// Single-request bus master driving an external single-port RAM over a shared tristate data bus.
// Optional address bounds checking is enabled with RAM_MASTER_BOUNDS_CHECK_EN.
module ram_bus_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe
);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              addr_ok;

`ifdef RAM_MASTER_BOUNDS_CHECK_EN
  logic err_reg;

  assign addr_ok = (req_addr < ADDR_W'(MEM_DEPTH));
  assign rsp_err = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE && req_valid) begin
      err_reg <= ~addr_ok;
    end
  end
`else
  assign addr_ok = 1'b1;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Out-of-range requests bypass the RAM and answer straight away.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (!addr_ok)    state_next = RESP;
          else if (req_we) state_next = WRITE;
          else             state_next = READ;
        end
      end
      WRITE:   state_next = RESP;
      READ:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capturing the request also clears the read data, so writes and rejects answer 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= '0;
      end else if (state_reg == READ) begin
        rdata_reg <= ram_data;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;

  assign ram_addr = addr_reg;
  assign ram_cs   = (state_reg == WRITE) || (state_reg == READ);
  assign ram_we   = (state_reg == WRITE);
  assign ram_oe   = (state_reg == READ);

  // Only WRITE drives the bus; RESP leaves a turnaround cycle after any read.
  assign ram_data = (state_reg == WRITE) ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: pairs it with a single-port synchronous RAM and a word-level reference memory.
module tb_ram_bus_master;

  localparam int AW    = 28;
  localparam int DW    = 32;
  localparam int DEPTH = 56;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int both_cnt = 0;
  int x_cnt = 0;
  int cs_cnt = 0;

  always #5 clk = ~clk;

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  // Single-port synchronous RAM: commits on rising edge, presents read data from the falling edge.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] ram_rd = '0;
  logic          ram_hit;
  assign ram_hit  = (ram_addr < AW'(DEPTH));
  assign ram_data = (ram_cs && ram_oe) ? ram_rd : {DW{1'bz}};

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0101);

  always @(posedge clk) if (ram_cs && ram_we && ram_hit) mem[ram_addr[5:0]] <= ram_data;
  always @(negedge clk) if (ram_cs && ram_oe) ram_rd <= ram_hit ? mem[ram_addr[5:0]] : '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (ram_oe && ram_we) both_cnt <= both_cnt + 1;
    if (ram_cs && $isunknown(ram_data)) x_cnt <= x_cnt + 1;
    if (ram_cs) cs_cnt <= cs_cnt + 1;
  end

  // Word-level reference memory
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a < AW'(DEPTH)) return ref_mem[a[5:0]];
    return '0;
  endfunction

  // Issues one request starting at a falling edge with IDLE expected; returns at the falling edge after the handshake.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int lat, output logic [DW-1:0] rd, output logic err, output int acc_cyc);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    acc_cyc = cyc_cnt;
    @(negedge clk);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    rd  = rsp_rdata;
    err = rsp_err;
    $display("txn we=%0b addr=%0d wdata=%h rdata=%h err=%0b lat=%0d", we, addr, wd, rd, err, lat);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_oe !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got cs/we/oe=%b%b%b exp=000", ram_cs, ram_we, ram_oe); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write_read();
    int lat, acc; logic [DW-1:0] rd; logic err;
    do_req(1'b1, AW'(5), 32'hDEADBEEF, lat, rd, err, acc);
    ref_mem[5] = 32'hDEADBEEF;
    checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    checks++; if (rd !== '0 || err !== 1'b0) begin errors++; $display("FAIL wr_rsp got rdata=%h err=%b exp 0/0", rd, err); end
    do_req(1'b0, AW'(5), '0, lat, rd, err, acc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    checks++; if (rd !== ref_read(AW'(5))) begin errors++; $display("FAIL rd_data got=%h exp=%h", rd, ref_read(AW'(5))); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", err); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] exp_rd;
    int n;
    exp_rd = ref_read(AW'(5));
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(5);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd) begin
      errors++; $display("FAIL stall_first got valid=%b rdata=%h exp valid=1 rdata=%h", rsp_valid, rsp_rdata, exp_rd); end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(5); req_wdata = $urandom;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got valid=%b rdata=%h ready=%b exp 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, exp_rd); end
    end
    $display("txn stall read addr=5 rdata=%h held 4 cycles", rsp_rdata);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int lat, acc1, acc2, b0, x0; logic [DW-1:0] rd; logic err;
    b0 = both_cnt; x0 = x_cnt;
    do_req(1'b0, AW'(7), '0, lat, rd, err, acc1);
    checks++; if (rd !== ref_read(AW'(7))) begin errors++; $display("FAIL b2b_read got=%h exp=%h", rd, ref_read(AW'(7))); end
    do_req(1'b1, AW'(7), 32'h12345678, lat, rd, err, acc2);
    ref_mem[7] = 32'h12345678;
    checks++; if (acc2 - acc1 !== 3) begin errors++; $display("FAIL b2b_spacing got=%0d exp=3", acc2 - acc1); end
    do_req(1'b0, AW'(7), '0, lat, rd, err, acc1);
    checks++; if (rd !== ref_read(AW'(7))) begin errors++; $display("FAIL b2b_readback got=%h exp=%h", rd, ref_read(AW'(7))); end
    checks++; if (both_cnt - b0 !== 0) begin errors++; $display("FAIL b2b_oe_we got=%0d exp=0 overlaps", both_cnt - b0); end
    checks++; if (x_cnt - x0 !== 0) begin errors++; $display("FAIL b2b_bus_x got=%0d exp=0 cycles", x_cnt - x0); end
  endtask

  task automatic test_reset_mid_write();
    int lat, acc, n, bad; logic [DW-1:0] rd; logic err;
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(9); req_wdata = 32'hA5A5A5A5;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin
      errors++; $display("FAIL midwr_in_write got cs/we=%b%b exp=11", ram_cs, ram_we); end
    rst = 1'b1;
    #1;
    checks++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_oe !== 1'b0) begin
      errors++; $display("FAIL midwr_ctrl_async got cs/we/oe=%b%b%b exp=000", ram_cs, ram_we, ram_oe); end
    @(negedge clk);
    checks++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_oe !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midwr_ctrl_hold got cs/we/oe/valid=%b%b%b%b exp=0000", ram_cs, ram_we, ram_oe, rsp_valid); end
    rst = 1'b0;
    bad = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midwr_no_rsp got=%0d exp=0 valid cycles", bad); end
    $display("txn reset during write addr=9 data=a5a5a5a5");
    do_req(1'b0, AW'(9), '0, lat, rd, err, acc);
    checks++; if (rd !== ref_read(AW'(9))) begin errors++; $display("FAIL midwr_readback got=%h exp=%h", rd, ref_read(AW'(9))); end
  endtask

  task automatic test_random();
    int lat, acc; logic [DW-1:0] rd, wd, exp; logic err, we; logic [AW-1:0] a;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      exp = we ? '0 : ref_read(a);
      do_req(we, a, wd, lat, rd, err, acc);
      if (we) ref_mem[a[5:0]] = wd;
      checks++; if (rd !== exp || err !== 1'b0 || lat !== 1) begin
        errors++; $display("FAIL rand%0d got rdata=%h err=%b lat=%0d exp %h/0/1", i, rd, err, lat, exp); end
    end
  endtask

  task automatic test_bounds();
    int lat, acc, c0; logic [DW-1:0] rd; logic err;
    c0 = cs_cnt;
    do_req(1'b0, AW'(56), '0, lat, rd, err, acc);
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
    checks++; if (err !== 1'b1 || rd !== '0) begin errors++; $display("FAIL bounds_rsp got err=%b rdata=%h exp 1/0", err, rd); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL bounds_latency got=%0d exp=0", lat); end
    checks++; if (cs_cnt - c0 !== 0) begin errors++; $display("FAIL bounds_cs got=%0d exp=0 cs cycles", cs_cnt - c0); end
`else
    checks++; if (err !== 1'b0 || rd !== '0) begin errors++; $display("FAIL bounds_rsp got err=%b rdata=%h exp 0/0", err, rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL bounds_latency got=%0d exp=1", lat); end
    checks++; if (cs_cnt - c0 !== 1) begin errors++; $display("FAIL bounds_cs got=%0d exp=1 cs cycles", cs_cnt - c0); end
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0101);
    test_reset();
    test_write_read();
    test_stall();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    test_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
